// File: rtl/cnt_ctrl_pkg.sv
// cnt_ctrl_pkg: shared definitions for the cnt_ctrl slice.
//   cmd_op_e  - command opcodes carried on cmd_op
//   state_e   - controller FSM states
//   pre_width - width needed to hold a prescaler count of 0..pre-1
package cnt_ctrl_pkg;

  typedef enum logic [1:0] {
    OpNop   = 2'b00,
    OpStart = 2'b01,
    OpStop  = 2'b10,
    OpLoad  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StHold = 2'b10,
    StDone = 2'b11
  } state_e;

  // A one-bit prescaler is kept even when PRE=1 so the register never collapses to zero width.
  function automatic int unsigned pre_width(input int unsigned pre);
    return (pre > 1) ? $clog2(pre) : 1;
  endfunction

endpackage

// File: rtl/cnt_core.sv
// cnt_core: W-bit terminal-count counter datapath.
//   clk, rstn - clock and asynchronous active-low reset
//   en        - advance one step this cycle
//   clr       - synchronous clear to 0 (wins over en)
//   tc        - terminal count; a step at or beyond tc returns to 0
//   nums      - registered count
//   wrap      - combinational: this cycle's step returns the count to 0
module cnt_core #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] tc,
  output logic [W-1:0] nums,
  output logic         wrap
);

  logic [W-1:0] nums_q, nums_d;

  // ">=" rather than "==" so a tc lowered below the held count still wraps at the next step.
  assign wrap = en & (nums_q >= tc);
  assign nums = nums_q;

  always_comb begin
    nums_d = nums_q;
    if (clr) begin
      nums_d = '0;
    end else if (en) begin
      nums_d = wrap ? '0 : nums_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nums_q <= '0;
    end else begin
      nums_q <= nums_d;
    end
  end

endmodule

// File: rtl/cnt_ctrl.sv
// cnt_ctrl: command-driven counter controller with prescaler and shadowed terminal count.
//   clk, rstn           - clock and asynchronous active-low reset
//   cmd_valid/cmd_ready - command handshake; ready is low only in the DONE cycle
//   cmd_op              - 00 NOP, 01 START, 10 STOP, 11 LOAD
//   cmd_data            - terminal count for LOAD
//   cmd_mode            - 0 one-shot, 1 auto-reload (sampled on START from IDLE)
//   nums                - current count
//   cout                - one-cycle pulse showing the count has wrapped to 0
//   done                - one-cycle pulse at one-shot completion
//   busy                - high while running or held
module cnt_ctrl #(
  parameter int unsigned W   = 4,
  parameter int unsigned PRE = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_data,
  input  logic         cmd_mode,
  output logic [W-1:0] nums,
  output logic         cout,
  output logic         done,
  output logic         busy
);

  import cnt_ctrl_pkg::*;

  localparam int unsigned PW = pre_width(PRE);
  localparam logic [PW-1:0] PreLast = PW'(PRE - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  tc_q, tc_d;
  logic [W-1:0]  tc_nxt_q, tc_nxt_d;
  logic          mode_q, mode_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic          cout_q, done_q;

  cmd_op_e op;
  logic    acc, is_start, is_stop, is_load;
  logic    step, wrap, core_clr;

  assign acc      = cmd_valid & cmd_ready;
  assign op       = cmd_op_e'(cmd_op);
  assign is_start = acc & (op == OpStart);
  assign is_stop  = acc & (op == OpStop);
  assign is_load  = acc & (op == OpLoad);

  // STOP on a step cycle suppresses the step, so no wrap, cout or done can follow it.
  assign step     = (state_q == StRun) & ~is_stop & (pre_cnt_q == PreLast);
  assign core_clr = (is_start & (state_q == StIdle)) | (is_stop & (state_q == StHold));

  cnt_core #(
    .W (W)
  ) u_core (
    .clk  (clk),
    .rstn (rstn),
    .en   (step),
    .clr  (core_clr),
    .tc   (tc_q),
    .nums (nums),
    .wrap (wrap)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (is_start) state_d = StRun;
      StRun: begin
        if (is_stop) begin
          state_d = StHold;
        end else if (wrap && !mode_q) begin
          state_d = StDone;
        end
      end
      StHold: begin
        if (is_start) begin
          state_d = StRun;
        end else if (is_stop) begin
          state_d = StIdle;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    cmd_ready = (state_q != StDone);
    busy      = (state_q == StRun) || (state_q == StHold);
  end

  // Prescaler, terminal counts and mode.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    tc_d      = tc_q;
    tc_nxt_d  = tc_nxt_q;
    mode_d    = mode_q;

    if (core_clr) begin
      pre_cnt_d = '0;
    end else if ((state_q == StRun) && !is_stop) begin
      pre_cnt_d = (pre_cnt_q == PreLast) ? '0 : pre_cnt_q + PW'(1);
    end

    if (is_start && (state_q == StIdle)) begin
      mode_d = cmd_mode;
    end

    // A wrap promotes the shadow value held before this cycle; a LOAD landing on the
    // same edge only updates the shadow and takes effect at the following wrap.
    if (wrap) begin
      tc_d = tc_nxt_q;
    end
    if (is_load) begin
      tc_nxt_d = cmd_data;
      if (state_q != StRun) begin
        tc_d = cmd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_cnt_q <= '0;
      tc_q      <= '1;
      tc_nxt_q  <= '1;
      mode_q    <= 1'b1;
      cout_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      tc_q      <= tc_d;
      tc_nxt_q  <= tc_nxt_d;
      mode_q    <= mode_d;
      cout_q    <= wrap;
      done_q    <= wrap & ~mode_q;
    end
  end

  assign cout = cout_q;
  assign done = done_q;

endmodule
